// File: rtl/vga_ctrl_pkg.sv
// Shared encodings for the display mode scheduler: FSM states, one-hot source
// selects, resolution codes and the slideshow source rotation.
package vga_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_WAIT_FS,
    ST_BLANKING,
    ST_APPLY,
    ST_SETTLE
  } state_e;

  localparam logic [2:0] SRC_STRIP = 3'b100;
  localparam logic [2:0] SRC_ROM   = 3'b010;
  localparam logic [2:0] SRC_GIF   = 3'b001;

  localparam logic [1:0] RES_640X480   = 2'b00;
  localparam logic [1:0] RES_800X600   = 2'b01;
  localparam logic [1:0] RES_1024X768  = 2'b10;
  localparam logic [1:0] RES_1280X1024 = 2'b11;

  // Slideshow order strip -> ROM -> GIF -> strip; anything unexpected restarts at strip.
  function automatic logic [2:0] next_src(input logic [2:0] src);
    case (src)
      SRC_STRIP: next_src = SRC_ROM;
      SRC_ROM:   next_src = SRC_GIF;
      default:   next_src = SRC_STRIP;
    endcase
  endfunction

  function automatic logic src_is_valid(input logic [2:0] src);
    src_is_valid = (src == SRC_STRIP) || (src == SRC_ROM) || (src == SRC_GIF);
  endfunction

endpackage

// File: rtl/sel_debounce.sv
// Debouncer for a multi-bit switch bundle: a value is taken as stable once it has
// been held for CYCLES consecutive clocks; a one-cycle pulse marks each acceptance.
module sel_debounce #(
  parameter int              WIDTH     = 5,
  parameter int              CYCLES    = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             accepted
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES);

  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accepted_q, accepted_d;

  always_comb begin
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    stable_d   = stable_q;
    accepted_d = 1'b0;
    if (raw != cand_q) begin
      cand_d = raw;
      cnt_d  = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    // Fire only on the cycle the hold count first reaches its target.
    if ((cnt_d == CNT_MAX) && ((cnt_q != CNT_MAX) || (raw != cand_q))) begin
      stable_d   = cand_d;
      accepted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q     <= RESET_VAL;
      cnt_q      <= '0;
      stable_q   <= RESET_VAL;
      accepted_q <= 1'b0;
    end else begin
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      stable_q   <= stable_d;
      accepted_q <= accepted_d;
    end
  end

  assign stable   = stable_q;
  assign accepted = accepted_q;

endmodule

// File: rtl/display_mode_scheduler.sv
// Applies source/resolution changes only at frame boundaries, wrapped in forced
// black frames, with an optional slideshow that rotates sources every few frames.
module display_mode_scheduler
  import vga_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLANK_FRAMES    = 2,
  parameter int DWELL_FRAMES    = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req_src,
  input  logic [1:0] req_res,
  input  logic       auto_en,
  input  logic       frame_start,
  output logic [2:0] src_sel,
  output logic [1:0] res_sel,
  output logic       blank,
  output logic       cfg_update,
  output logic       busy
);

  localparam int DW = $clog2(DWELL_FRAMES + 1);
  localparam int BW = $clog2(BLANK_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_FRAMES);
  localparam logic [BW-1:0] BLANK_MAX = BW'(BLANK_FRAMES);

  logic [4:0] db_stable;
  logic       db_accepted;

  sel_debounce #(
    .WIDTH    (5),
    .CYCLES   (DEBOUNCE_CYCLES),
    .RESET_VAL({SRC_STRIP, RES_640X480})
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .raw     ({req_src, req_res}),
    .stable  (db_stable),
    .accepted(db_accepted)
  );

  state_e        state_q, state_d;
  logic [2:0]    src_sel_q, src_sel_d;
  logic [1:0]    res_sel_q, res_sel_d;
  logic          blank_q, blank_d;
  logic          cfg_update_q, cfg_update_d;
  logic          busy_q, busy_d;
  logic [2:0]    tgt_src_q, tgt_src_d;
  logic [1:0]    tgt_res_q, tgt_res_d;
  logic [2:0]    acc_src_q, acc_src_d;
  logic [1:0]    acc_res_q, acc_res_d;
  logic          pend_q, pend_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  logic          req_diff;
  logic [DW-1:0] dwell_inc;
  logic [BW-1:0] bcnt_inc;
  logic [2:0]    eff_src;
  logic [1:0]    eff_res;

  always_comb begin
    state_d      = state_q;
    src_sel_d    = src_sel_q;
    res_sel_d    = res_sel_q;
    blank_d      = blank_q;
    cfg_update_d = 1'b0;
    busy_d       = busy_q;
    tgt_src_d    = tgt_src_q;
    tgt_res_d    = tgt_res_q;
    acc_src_d    = acc_src_q;
    acc_res_d    = acc_res_q;
    pend_d       = pend_q;
    dwell_d      = dwell_q;
    bcnt_d       = bcnt_q;

    req_diff  = {acc_src_q, acc_res_q} != {src_sel_q, res_sel_q};
    dwell_inc = (dwell_q == DWELL_MAX) ? DWELL_MAX : dwell_q + DW'(1);
    bcnt_inc  = (bcnt_q == BLANK_MAX) ? BLANK_MAX : bcnt_q + BW'(1);
    eff_src   = pend_q ? acc_src_q : tgt_src_q;
    eff_res   = pend_q ? acc_res_q : tgt_res_q;

    case (state_q)
      ST_RUN: begin
        if (pend_q && req_diff) begin
          tgt_src_d = acc_src_q;
          tgt_res_d = acc_res_q;
          busy_d    = 1'b1;
          dwell_d   = '0;
          pend_d    = 1'b0;
          state_d   = ST_WAIT_FS;
        end else begin
          pend_d = 1'b0;
          if (!auto_en) begin
            dwell_d = '0;
          end else if (frame_start) begin
            if (dwell_inc == DWELL_MAX) begin
              tgt_src_d = next_src(src_sel_q);
              tgt_res_d = res_sel_q;
              busy_d    = 1'b1;
              dwell_d   = '0;
              state_d   = ST_WAIT_FS;
            end else begin
              dwell_d = dwell_inc;
            end
          end
        end
      end
      ST_WAIT_FS: begin
        if (frame_start) begin
          blank_d = 1'b1;
          bcnt_d  = '0;
          state_d = ST_BLANKING;
        end else if (pend_q) begin
          // A request that reverts to the applied config cancels before any blanking.
          pend_d = 1'b0;
          if (!req_diff) begin
            busy_d  = 1'b0;
            state_d = ST_RUN;
          end else begin
            tgt_src_d = acc_src_q;
            tgt_res_d = acc_res_q;
          end
        end
      end
      ST_BLANKING: begin
        tgt_src_d = eff_src;
        tgt_res_d = eff_res;
        pend_d    = 1'b0;
        if (frame_start) begin
          bcnt_d = bcnt_inc;
          if (bcnt_inc == BLANK_MAX) begin
            src_sel_d    = eff_src;
            res_sel_d    = eff_res;
            cfg_update_d = 1'b1;
            state_d      = ST_APPLY;
          end
        end
      end
      ST_APPLY: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (frame_start) begin
          blank_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Capture after the FSM so a fresh acceptance is never lost to a same-cycle clear.
    if (db_accepted) begin
      acc_res_d = db_stable[1:0];
      if (src_is_valid(db_stable[4:2])) begin
        acc_src_d = db_stable[4:2];
      end
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      src_sel_q    <= SRC_STRIP;
      res_sel_q    <= RES_640X480;
      blank_q      <= 1'b0;
      cfg_update_q <= 1'b0;
      busy_q       <= 1'b0;
      tgt_src_q    <= SRC_STRIP;
      tgt_res_q    <= RES_640X480;
      acc_src_q    <= SRC_STRIP;
      acc_res_q    <= RES_640X480;
      pend_q       <= 1'b0;
      dwell_q      <= '0;
      bcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      src_sel_q    <= src_sel_d;
      res_sel_q    <= res_sel_d;
      blank_q      <= blank_d;
      cfg_update_q <= cfg_update_d;
      busy_q       <= busy_d;
      tgt_src_q    <= tgt_src_d;
      tgt_res_q    <= tgt_res_d;
      acc_src_q    <= acc_src_d;
      acc_res_q    <= acc_res_d;
      pend_q       <= pend_d;
      dwell_q      <= dwell_d;
      bcnt_q       <= bcnt_d;
    end
  end

  assign src_sel    = src_sel_q;
  assign res_sel    = res_sel_q;
  assign blank      = blank_q;
  assign cfg_update = cfg_update_q;
  assign busy       = busy_q;

endmodule
